// File: rtl/retire_free_list_if.sv
// Retire/free-list bus between the ROB/rename side and retire_free_list.
//   master : rename/ROB side. Drives alloc_req, commit_*, flush and
//            observes alloc_valid/alloc_preg, rrat_map and free_count.
//   slave  : retire_free_list itself.
interface retire_free_list_if #(
  parameter int NUM_REGS = 64
) ();
  localparam int PW    = $clog2(NUM_REGS);
  localparam int DEPTH = NUM_REGS - 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            alloc_req;
  logic            alloc_valid;
  logic [PW-1:0]   alloc_preg;
  logic            commit_valid;
  logic [4:0]      commit_arch_rd;
  logic [PW-1:0]   commit_phys_rd;
  logic            flush;
  logic [32*PW-1:0] rrat_map;
  logic [CW-1:0]   free_count;

  modport master (
    output alloc_req, commit_valid, commit_arch_rd, commit_phys_rd, flush,
    input  alloc_valid, alloc_preg, rrat_map, free_count
  );

  modport slave (
    input  alloc_req, commit_valid, commit_arch_rd, commit_phys_rd, flush,
    output alloc_valid, alloc_preg, rrat_map, free_count
  );
endinterface

// File: rtl/retire_free_list.sv
// Retirement RAT plus circular free list of physical registers.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of retire_free_list_if
//     alloc_req/alloc_valid/alloc_preg : show-ahead pop port toward rename
//     commit_valid/commit_arch_rd/commit_phys_rd : one retirement per cycle
//     flush    : recovery; rebuilds the free list from the RRAT
//     rrat_map : registered RRAT, entry i at [i*PW +: PW]
//     free_count : number of valid free-list entries
module retire_free_list #(
  parameter int NUM_REGS = 64
) (
  input  logic            clk,
  input  logic            rst,
  retire_free_list_if.slave bus
);
  localparam int DEPTH = NUM_REGS - 32;
  localparam int PW    = $clog2(NUM_REGS);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int HW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [HW-1:0] LAST_C  = HW'(DEPTH - 1);

  logic [PW-1:0] rrat_q [32];
  logic [PW-1:0] rrat_d [32];
  logic [PW-1:0] fl_q [DEPTH];
  logic [PW-1:0] fl_d [DEPTH];
  logic [HW-1:0] head_q, head_d;
  logic [HW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          alloc_valid;
  logic          push;
  logic          pop;
  logic [PW-1:0] old_preg;

  function automatic logic [HW-1:0] wrap_inc(input logic [HW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign alloc_valid     = (count_q != '0);
  assign bus.alloc_valid = alloc_valid;
  assign bus.alloc_preg  = fl_q[head_q];
  assign bus.free_count  = count_q;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_rrat_map
      assign bus.rrat_map[gi*PW +: PW] = rrat_q[gi];
    end
  endgenerate

  always_comb begin
    push     = bus.commit_valid && (bus.commit_arch_rd != 5'd0);
    // A flush discards rename's same-cycle pop.
    pop      = bus.alloc_req && alloc_valid && !bus.flush;
    old_preg = rrat_q[bus.commit_arch_rd];
    rrat_d   = rrat_q;
    fl_d     = fl_q;
    tail_d   = tail_q;
    head_d   = head_q;
    count_d  = count_q;

    // The superseded mapping goes back to the free list at tail.
    if (push) begin
      rrat_d[bus.commit_arch_rd] = bus.commit_phys_rd;
      fl_d[tail_q]               = old_preg;
      tail_d                     = wrap_inc(tail_q);
    end

    if (bus.flush) begin
      // The DEPTH slots from the post-retire tail onward are exactly the
      // registers not named by the updated RRAT, so the list becomes full.
      head_d  = tail_d;
      count_d = DEPTH_C;
    end else begin
      if (pop) head_d = wrap_inc(head_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rrat_q[i] <= PW'(i);
      for (int j = 0; j < DEPTH; j++) fl_q[j] <= PW'(32 + j);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= DEPTH_C;
    end else begin
      rrat_q  <= rrat_d;
      fl_q    <= fl_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Retiring into a full list would overwrite a live free entry.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (rst) !(push && count_q == DEPTH_C)
  );
endmodule

// File: tb/tb_retire_free_list.sv
module tb_retire_free_list;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  retire_free_list_if #(.NUM_REGS(64)) bus ();

  retire_free_list #(.NUM_REGS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string name;
    int    kind;  // 0 alloc_valid, 1 alloc_preg, 2 free_count, 3 rrat entry
    int    idx;
    int    exp;
  } chk_t;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   alloc_q[$];
  chk_t chk_q[$];

  function automatic int read_st(input int kind, input int idx);
    case (kind)
      0:       return int'(bus.alloc_valid);
      1:       return int'(bus.alloc_preg);
      2:       return int'(bus.free_count);
      default: return int'(bus.rrat_map[idx*6 +: 6]);
    endcase
  endfunction

  // Monitor: status expectations are evaluated mid-cycle; every accepted
  // pop is matched against the next expected register.
  always @(negedge clk) begin : monitor
    chk_t c;
    int   act;
    int   e;
    while (chk_q.size() > 0) begin
      c   = chk_q.pop_front();
      act = read_st(c.kind, c.idx);
      tests_run++;
      if (act != c.exp) begin
        tests_failed++;
        $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
      end else begin
        $display("[TB] ok %s = %0d", c.name, act);
      end
    end
    if (!rst && bus.alloc_req && bus.alloc_valid && !bus.flush) begin
      tests_run++;
      if (alloc_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_pop: got preg %0d expected no pop", bus.alloc_preg);
      end else begin
        e = alloc_q.pop_front();
        if (int'(bus.alloc_preg) != e) begin
          tests_failed++;
          $display("FAIL pop: got preg %0d expected %0d", bus.alloc_preg, e);
        end else begin
          $display("[TB] ok pop preg %0d", e);
        end
      end
    end
  end

  task automatic expect_st(input string name, input int kind, input int idx, input int exp);
    chk_t c;
    c.name = name; c.kind = kind; c.idx = idx; c.exp = exp;
    chk_q.push_back(c);
  endtask

  task automatic clear_inputs();
    bus.alloc_req      = 1'b0;
    bus.commit_valid   = 1'b0;
    bus.commit_arch_rd = 5'd0;
    bus.commit_phys_rd = 6'd0;
    bus.flush          = 1'b0;
  endtask

  // One cycle of stimulus; exp >= 0 is the register the pop must return.
  task automatic cyc(input bit req, input bit cv, input int ard, input int prd,
                     input bit fl, input int exp);
    bus.alloc_req      = req;
    bus.commit_valid   = cv;
    bus.commit_arch_rd = 5'(ard);
    bus.commit_phys_rd = 6'(prd);
    bus.flush          = fl;
    if (exp >= 0) alloc_q.push_back(exp);
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 0, 0, 1'b0, -1);
  endtask

  task automatic pop_exp(input int e);
    cyc(1'b1, 1'b0, 0, 0, 1'b0, e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic end_test(input string name);
    idle();
    tests_run++;
    if (alloc_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_pending_pops: got %0d outstanding expected 0", name, alloc_q.size());
    end
    alloc_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    do_reset();

    // Reset state
    expect_st("rst_valid", 0, 0, 1);
    expect_st("rst_preg", 1, 0, 32);
    expect_st("rst_count", 2, 0, 32);
    expect_st("rst_rrat5", 3, 5, 5);
    expect_st("rst_rrat31", 3, 31, 31);
    end_test("reset");

    // Drain the whole list, then an ignored request while empty
    for (int i = 0; i < 32; i++) pop_exp(32 + i);
    expect_st("drain_valid", 0, 0, 0);
    expect_st("drain_count", 2, 0, 0);
    cyc(1'b1, 1'b0, 0, 0, 1'b0, -1);
    expect_st("empty_req_count", 2, 0, 0);
    expect_st("empty_req_valid", 0, 0, 0);
    expect_st("empty_req_preg", 1, 0, 32);
    end_test("drain");

    // Retire supersedes arch 5; physical 5 comes back after the wrap
    do_reset();
    pop_exp(32); pop_exp(33); pop_exp(34);
    expect_st("pre_commit_count", 2, 0, 29);
    cyc(1'b0, 1'b1, 5, 32, 1'b0, -1);
    expect_st("commit_count", 2, 0, 30);
    expect_st("commit_rrat5", 3, 5, 32);
    for (int i = 35; i < 64; i++) pop_exp(i);
    pop_exp(5);
    expect_st("wrap_count", 2, 0, 0);
    end_test("retire");

    // Retire to x0 is a no-op
    do_reset();
    pop_exp(32);
    cyc(1'b0, 1'b1, 0, 40, 1'b0, -1);
    expect_st("x0_count", 2, 0, 31);
    expect_st("x0_rrat0", 3, 0, 0);
    expect_st("x0_preg", 1, 0, 33);
    end_test("x0");

    // Simultaneous pop and push at count 10, then push into an empty list
    do_reset();
    for (int i = 0; i < 22; i++) pop_exp(32 + i);
    expect_st("pre_both_count", 2, 0, 10);
    cyc(1'b1, 1'b1, 3, 32, 1'b0, 54);
    expect_st("both_count", 2, 0, 10);
    expect_st("both_rrat3", 3, 3, 32);
    expect_st("both_preg", 1, 0, 55);
    for (int i = 55; i < 64; i++) pop_exp(i);
    pop_exp(3);
    expect_st("empty_count", 2, 0, 0);
    expect_st("no_bypass_valid", 0, 0, 0);
    cyc(1'b0, 1'b1, 4, 33, 1'b0, -1);
    expect_st("refill_valid", 0, 0, 1);
    expect_st("refill_preg", 1, 0, 4);
    expect_st("refill_count", 2, 0, 1);
    expect_st("refill_rrat4", 3, 4, 33);
    end_test("simul");

    // Flush together with the second commit (and a discarded pop)
    do_reset();
    for (int i = 0; i < 5; i++) pop_exp(32 + i);
    cyc(1'b0, 1'b1, 1, 32, 1'b0, -1);
    cyc(1'b1, 1'b1, 2, 33, 1'b1, -1);
    expect_st("flush_count", 2, 0, 32);
    expect_st("flush_rrat1", 3, 1, 32);
    expect_st("flush_rrat2", 3, 2, 33);
    expect_st("flush_valid", 0, 0, 1);
    expect_st("flush_preg", 1, 0, 34);
    for (int i = 34; i < 64; i++) pop_exp(i);
    pop_exp(1);
    pop_exp(2);
    expect_st("post_flush_count", 2, 0, 0);
    end_test("flush");

    // Flush while already full
    do_reset();
    cyc(1'b0, 1'b0, 0, 0, 1'b1, -1);
    expect_st("full_flush_count", 2, 0, 32);
    expect_st("full_flush_preg", 1, 0, 32);
    end_test("full_flush");

    // Asynchronous reset mid-operation takes effect before any clock edge
    do_reset();
    pop_exp(32); pop_exp(33); pop_exp(34);
    rst = 1'b1;
    #1;
    expect_st("async_count", 2, 0, 32);
    expect_st("async_preg", 1, 0, 32);
    @(posedge clk);
    #1;
    rst = 1'b0;
    alloc_q.delete();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
